// File: rtl/ddr_mode_controller.sv
// DDR game-mode controller: conditions the reset, pause and combo inputs and
// sequences RESET -> COUNTDOWN -> GAME <-> PAUSE -> OVER.

module ddr_mode_debounce #(
    parameter int   DEBOUNCE_CYCLES = 250000,
    parameter int   CNT_W           = 28,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic arst,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // The synchroniser resets to the filtered value so release from reset
    // never looks like an input edge.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync <= {2{RST_VAL}};
            cnt  <= '0;
            filt <= RST_VAL;
        end else if (rst) begin
            sync <= {2{RST_VAL}};
            cnt  <= '0;
            filt <= RST_VAL;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

module ddr_mode_controller #(
    parameter int STATE_BITS       = 2,
    parameter int DEBOUNCE_CYCLES  = 250000,
    parameter int COUNTDOWN_CYCLES = 150000000,
    parameter int CNT_W            = 28
) (
    input  logic              clk,
    input  logic              btnR,
    input  logic              btnL,
    input  logic              pauseSwitch,
    input  logic              song_done,
    output logic [STATE_BITS:0] output_state,
    output logic              display_combo_en,
    output logic              game_start
);

    localparam int SW = STATE_BITS + 1;

    typedef enum logic [STATE_BITS:0] {
        S_RESET     = SW'(0),
        S_PAUSE     = SW'(1),
        S_GAME      = SW'(2),
        S_COUNTDOWN = SW'(3),
        S_OVER      = SW'(4)
    } mode_t;

    logic [1:0]       rst_sr;
    logic             rst;
    logic             pause_filt;
    logic             btnl_filt;
    logic             btnl_filt_d;
    logic             btnl_press;
    logic [CNT_W-1:0] cd_cnt;
    mode_t            state;

    // Reset stays asserted for two edges after btnR falls.
    always_ff @(posedge clk or posedge btnR) begin
        if (btnR) rst_sr <= 2'b11;
        else      rst_sr <= {1'b0, rst_sr[1]};
    end
    assign rst = rst_sr[0];

    ddr_mode_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .RST_VAL(1'b1)
    ) u_pause_db (
        .clk(clk), .arst(btnR), .rst(rst), .raw(pauseSwitch), .filt(pause_filt)
    );

    ddr_mode_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .RST_VAL(1'b0)
    ) u_btnl_db (
        .clk(clk), .arst(btnR), .rst(rst), .raw(btnL), .filt(btnl_filt)
    );

    always_ff @(posedge clk or posedge btnR) begin
        if (btnR)     btnl_filt_d <= 1'b0;
        else if (rst) btnl_filt_d <= 1'b0;
        else          btnl_filt_d <= btnl_filt;
    end
    assign btnl_press = btnl_filt & ~btnl_filt_d;

    // Combo display survives only while staying in PAUSE or OVER; every
    // transition out of those states clears it on the same edge.
    always_ff @(posedge clk or posedge btnR) begin
        if (btnR) begin
            state            <= S_RESET;
            cd_cnt           <= '0;
            display_combo_en <= 1'b0;
            game_start       <= 1'b0;
        end else if (rst) begin
            state            <= S_RESET;
            cd_cnt           <= '0;
            display_combo_en <= 1'b0;
            game_start       <= 1'b0;
        end else begin
            game_start <= 1'b0;
            case (state)
                S_RESET: begin
                    display_combo_en <= 1'b0;
                    if (!pause_filt) begin
                        state  <= S_COUNTDOWN;
                        cd_cnt <= CNT_W'(COUNTDOWN_CYCLES - 1);
                    end
                end
                S_COUNTDOWN: begin
                    display_combo_en <= 1'b0;
                    if (pause_filt) begin
                        state <= S_PAUSE;
                    end else if (cd_cnt == '0) begin
                        state      <= S_GAME;
                        game_start <= 1'b1;
                    end else begin
                        cd_cnt <= cd_cnt - CNT_W'(1);
                    end
                end
                S_GAME: begin
                    display_combo_en <= 1'b0;
                    if (song_done)       state <= S_OVER;
                    else if (pause_filt) state <= S_PAUSE;
                end
                S_PAUSE: begin
                    if (!pause_filt) begin
                        state            <= S_COUNTDOWN;
                        cd_cnt           <= CNT_W'(COUNTDOWN_CYCLES - 1);
                        display_combo_en <= 1'b0;
                    end else if (btnl_press) begin
                        display_combo_en <= ~display_combo_en;
                    end
                end
                S_OVER: begin
                    if (btnl_press) display_combo_en <= ~display_combo_en;
                end
                default: begin
                    state            <= S_RESET;
                    display_combo_en <= 1'b0;
                end
            endcase
        end
    end

    assign output_state = state;

endmodule

// File: tb/tb_ddr_mode_controller.sv
// Directed bench for ddr_mode_controller with a per-cycle expected-output queue
// ({game_start, display_combo_en, output_state}) compared after each edge.

module tb_ddr_mode_controller;

    localparam logic [2:0] ST_RESET = 3'd0;
    localparam logic [2:0] ST_PAUSE = 3'd1;
    localparam logic [2:0] ST_GAME  = 3'd2;
    localparam logic [2:0] ST_CD    = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    logic       clk;
    logic       btnR;
    logic       btnL;
    logic       pauseSwitch;
    logic       song_done;
    logic [2:0] output_state;
    logic       display_combo_en;
    logic       game_start;

    logic [4:0] exp_q[$];
    int         n_checks;
    int         n_pass;
    int         n_fail;

    ddr_mode_controller #(
        .STATE_BITS(2),
        .DEBOUNCE_CYCLES(4),
        .COUNTDOWN_CYCLES(8),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .btnR(btnR),
        .btnL(btnL),
        .pauseSwitch(pauseSwitch),
        .song_done(song_done),
        .output_state(output_state),
        .display_combo_en(display_combo_en),
        .game_start(game_start)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_now(input string tag);
        logic [4:0] got;
        logic [4:0] exp;
        got = {game_start, display_combo_en, output_state};
        exp = exp_q.pop_front();
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed st=%0d gs=%b ce=%b expected st=%0d gs=%b ce=%b",
                   tag, got[2:0], got[4], got[3], exp[2:0], exp[4], exp[3]);
        end
    endtask

    task automatic expect_now(input string tag, input logic [2:0] st,
                              input logic gs, input logic ce);
        exp_q.push_back({gs, ce, st});
        check_now(tag);
    endtask

    task automatic cycles(input int n, input logic [2:0] st, input logic gs,
                          input logic ce, input string tag);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({gs, ce, st});
            @(posedge clk);
            #1;
            check_now(tag);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        n_fail      = 0;
        btnR        = 1'b0;
        btnL        = 1'b0;
        pauseSwitch = 1'b0;
        song_done   = 1'b0;

        // 1. power-up
        #2 btnR = 1'b1;
        #1 expect_now("reset_async", ST_RESET, 1'b0, 1'b0);
        cycles(3, ST_RESET, 1'b0, 1'b0, "reset_hold");
        btnR = 1'b0;
        cycles(8, ST_RESET, 1'b0, 1'b0, "pwr_reset");
        cycles(8, ST_CD,    1'b0, 1'b0, "pwr_countdown");
        cycles(1, ST_GAME,  1'b1, 1'b0, "pwr_start");
        cycles(1, ST_GAME,  1'b0, 1'b0, "pwr_game");

        // 2. glitch rejection then real pause/resume
        pauseSwitch = 1'b1;
        cycles(3, ST_GAME, 1'b0, 1'b0, "glitch");
        pauseSwitch = 1'b0;
        cycles(10, ST_GAME, 1'b0, 1'b0, "glitch_reject");
        pauseSwitch = 1'b1;
        cycles(6, ST_GAME,  1'b0, 1'b0, "pause_latency");
        cycles(4, ST_PAUSE, 1'b0, 1'b0, "paused");
        pauseSwitch = 1'b0;
        cycles(6, ST_PAUSE, 1'b0, 1'b0, "resume_latency");
        cycles(8, ST_CD,    1'b0, 1'b0, "resume_countdown");
        cycles(1, ST_GAME,  1'b1, 1'b0, "resume_start");
        cycles(1, ST_GAME,  1'b0, 1'b0, "resume_game");

        // 3. combo toggle in PAUSE
        pauseSwitch = 1'b1;
        cycles(6, ST_GAME,  1'b0, 1'b0, "combo_enter_lat");
        cycles(2, ST_PAUSE, 1'b0, 1'b0, "combo_enter");
        btnL = 1'b1;
        cycles(6, ST_PAUSE, 1'b0, 1'b0, "press1_lat");
        btnL = 1'b0;
        cycles(8, ST_PAUSE, 1'b0, 1'b1, "combo_on");
        btnL = 1'b1;
        cycles(6, ST_PAUSE, 1'b0, 1'b1, "press2_lat");
        btnL = 1'b0;
        cycles(8, ST_PAUSE, 1'b0, 1'b0, "combo_off");
        btnL = 1'b1;
        cycles(6, ST_PAUSE, 1'b0, 1'b0, "press3_lat");
        btnL = 1'b0;
        cycles(8, ST_PAUSE, 1'b0, 1'b1, "combo_on_again");
        pauseSwitch = 1'b0;
        cycles(6, ST_PAUSE, 1'b0, 1'b1, "combo_resume_lat");
        cycles(8, ST_CD,    1'b0, 1'b0, "combo_cleared");
        cycles(1, ST_GAME,  1'b1, 1'b0, "combo_start");
        cycles(1, ST_GAME,  1'b0, 1'b0, "combo_game");
        btnL = 1'b1;
        cycles(6, ST_GAME, 1'b0, 1'b0, "game_press_lat");
        btnL = 1'b0;
        cycles(8, ST_GAME, 1'b0, 1'b0, "game_press_ignored");

        // 4. song_done and pause in the same cycle; OVER is terminal
        pauseSwitch = 1'b1;
        cycles(6, ST_GAME, 1'b0, 1'b0, "over_pause_lat");
        song_done = 1'b1;
        cycles(1, ST_OVER, 1'b0, 1'b0, "over_wins");
        song_done = 1'b0;
        cycles(4, ST_OVER, 1'b0, 1'b0, "over_hold");
        pauseSwitch = 1'b0;
        cycles(10, ST_OVER, 1'b0, 1'b0, "over_unpause");
        song_done = 1'b1;
        cycles(2, ST_OVER, 1'b0, 1'b0, "over_song_done");
        song_done   = 1'b0;
        pauseSwitch = 1'b1;
        cycles(8, ST_OVER, 1'b0, 1'b0, "over_pause");
        pauseSwitch = 1'b0;
        cycles(8, ST_OVER, 1'b0, 1'b0, "over_unpause2");
        btnL = 1'b1;
        cycles(6, ST_OVER, 1'b0, 1'b0, "over_press_lat");
        btnL = 1'b0;
        cycles(8, ST_OVER, 1'b0, 1'b1, "over_combo");
        #2 btnR = 1'b1;
        #1 expect_now("over_reset_async", ST_RESET, 1'b0, 1'b0);
        cycles(3, ST_RESET, 1'b0, 1'b0, "over_reset_hold");
        btnR = 1'b0;

        // 5. pause during countdown with counter at 3, then a full recount
        cycles(7, ST_RESET, 1'b0, 1'b0, "cdp_reset");
        pauseSwitch = 1'b1;
        cycles(1, ST_RESET, 1'b0, 1'b0, "cdp_reset_last");
        cycles(5, ST_CD,    1'b0, 1'b0, "cdp_countdown");
        cycles(6, ST_PAUSE, 1'b0, 1'b0, "cdp_paused");
        pauseSwitch = 1'b0;
        cycles(6, ST_PAUSE, 1'b0, 1'b0, "cdp_resume_lat");
        cycles(8, ST_CD,    1'b0, 1'b0, "cdp_recount");
        cycles(1, ST_GAME,  1'b1, 1'b0, "cdp_start");
        cycles(1, ST_GAME,  1'b0, 1'b0, "cdp_game");

        // 6. reset mid-countdown with the pause switch held on
        pauseSwitch = 1'b1;
        cycles(6, ST_GAME,  1'b0, 1'b0, "r6_pause_lat");
        cycles(2, ST_PAUSE, 1'b0, 1'b0, "r6_paused");
        pauseSwitch = 1'b0;
        cycles(6, ST_PAUSE, 1'b0, 1'b0, "r6_resume_lat");
        cycles(2, ST_CD,    1'b0, 1'b0, "r6_countdown");
        pauseSwitch = 1'b1;
        #2 btnR = 1'b1;
        #1 expect_now("cd_reset_async", ST_RESET, 1'b0, 1'b0);
        cycles(3, ST_RESET, 1'b0, 1'b0, "cd_reset_hold");
        btnR = 1'b0;
        cycles(20, ST_RESET, 1'b0, 1'b0, "reset_stays_paused");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
